// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings, FSM states and helpers for the iterative RV32M mul/div unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = XLEN;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam int unsigned REM_W = XLEN + 1;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam int unsigned RD_W  = 5;
  localparam int unsigned F3_W  = 3;

  localparam logic [F3_W-1:0] OP_MUL    = 3'b000;
  localparam logic [F3_W-1:0] OP_MULH   = 3'b001;
  localparam logic [F3_W-1:0] OP_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] OP_MULHU  = 3'b011;
  localparam logic [F3_W-1:0] OP_DIV    = 3'b100;
  localparam logic [F3_W-1:0] OP_DIVU   = 3'b101;
  localparam logic [F3_W-1:0] OP_REM    = 3'b110;
  localparam logic [F3_W-1:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Context captured when an operation is accepted.
  typedef struct packed {
    logic [F3_W-1:0] op;
    logic [RD_W-1:0] rd;
    logic            neg;
  } op_ctx_t;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the mul/div unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [F3_W-1:0] funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [RD_W-1:0] rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  modport master (
    output start, funct3, a, b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, a, b, rd_in, flush,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a shift-add multiply step or a restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic             div_mode,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [REM_W-1:0] rem_in,
  input  logic [XLEN-1:0]  opnd,
  output logic [ACC_W-1:0] acc_out,
  output logic [REM_W-1:0] rem_out,
  output logic             q_bit
);

  logic [REM_W-1:0] sum;
  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] diff;

  // Multiply: acc = {partial, multiplier}, shifted right each step.
  // Divide: acc[XLEN-1:0] shifts the dividend out at the MSB; the top inserts q_bit at the LSB.
  always_comb begin
    sum     = {1'b0, acc_in[ACC_W-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
    rem_sh  = {rem_in[XLEN-1:0], acc_in[XLEN-1]};
    diff    = rem_sh - {1'b0, opnd};
    q_bit   = 1'b0;
    rem_out = rem_in;
    acc_out = {sum, acc_in[XLEN-1:1]};
    if (div_mode) begin
      q_bit   = ~diff[XLEN];
      rem_out = diff[XLEN] ? rem_sh : diff;
      acc_out = {acc_in[ACC_W-1:XLEN], acc_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring division with sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     clk,
  input logic     rstn,
  muldiv_if.slave bus
);

  state_t           state, state_d;
  op_ctx_t          ctx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [REM_W-1:0] rem_q;
  logic [XLEN-1:0]  opnd_q;
  logic [XLEN-1:0]  result_q;
  logic [RD_W-1:0]  rd_out_q;
  logic             busy_q, done_q;

  logic             busy_d, done_d, launch, fast, step_en, fix;
  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem, div_zero, div_ovf, res_neg;
  logic [XLEN-1:0]  mag_a, mag_b, spec_val, fix_val;
  logic [ACC_W-1:0] prod, step_acc, acc_next;
  logic [REM_W-1:0] step_rem;
  logic             step_q;
  logic             unused_bits;

  // Operand signedness, magnitudes and the divide corner cases, all from the live request.
  always_comb begin
    a_sgn    = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_MULHSU) ||
               (bus.funct3 == OP_DIV)  || (bus.funct3 == OP_REM);
    b_sgn    = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM);
    a_neg    = a_sgn & bus.a[XLEN-1];
    b_neg    = b_sgn & bus.b[XLEN-1];
    mag_a    = neg_if(a_neg, bus.a);
    mag_b    = neg_if(b_neg, bus.b);
    is_div   = bus.funct3[2];
    is_rem   = bus.funct3[2] & bus.funct3[1];
    div_zero = is_div && (bus.b == '0);
    div_ovf  = is_div && !bus.funct3[0] && (bus.a == INT_MIN) && (bus.b == '1);
    res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
    if (div_zero) spec_val = is_rem ? bus.a : '1;
    else          spec_val = is_rem ? '0 : INT_MIN;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    launch  = 1'b0;
    fast    = 1'b0;
    step_en = 1'b0;
    fix     = 1'b0;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (div_zero || div_ovf) begin
              fast    = 1'b1;
              state_d = S_DONE;
            end else begin
              launch  = 1'b1;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          step_en = 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          fix     = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  muldiv_step u_step (
    .div_mode (ctx_q.op[2]),
    .acc_in   (acc_q),
    .rem_in   (rem_q),
    .opnd     (opnd_q),
    .acc_out  (step_acc),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  assign acc_next = ctx_q.op[2] ? {step_acc[ACC_W-1:1], step_q} : step_acc;

  // Sign fix-up and result selection from the finished magnitudes.
  always_comb begin
    prod = ctx_q.neg ? ACC_W'(-acc_q) : acc_q;
    case (ctx_q.op)
      OP_MUL:                      fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[ACC_W-1:XLEN];
      OP_DIV, OP_DIVU:             fix_val = neg_if(ctx_q.neg, acc_q[XLEN-1:0]);
      default:                     fix_val = neg_if(ctx_q.neg, rem_q[XLEN-1:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctx_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (launch) begin
        ctx_q  <= '{op: bus.funct3, rd: bus.rd_in, neg: res_neg};
        cnt_q  <= '0;
        acc_q  <= {{XLEN{1'b0}}, mag_a};
        rem_q  <= '0;
        opnd_q <= mag_b;
      end else if (step_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= acc_next;
        rem_q <= step_rem;
      end
      if (fast) begin
        result_q <= spec_val;
        rd_out_q <= bus.rd_in;
      end else if (fix) begin
        result_q <= fix_val;
        rd_out_q <= ctx_q.rd;
      end
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // The remainder borrow bit is only needed inside the step.
  assign unused_bits = rem_q[XLEN];

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, q;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy = {32'b0, y};
    case (f)
      OP_MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0];  end
      OP_MULH:   begin p = sx * sy;                 return p[63:32]; end
      OP_MULHSU: begin p = sx * uy;                 return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sx / sy;
        return q[31:0];
      end
      OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = sx % sy;
        return q[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rd);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.a      = x;
    bus.b      = y;
    bus.rd_in  = rd;
  endtask

  task automatic wait_done(input int limit, output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (!bus.done && cyc < limit) begin
      if (bus.busy) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  // Issue one op, then check latency, busy window, result, tag and the single-cycle done.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] rd, input logic [31:0] exp);
    int cyc, bc;
    bit sp;
    sp = f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    drive(f, x, y, rd);
    tick();
    bus.start = 1'b0;
    wait_done(60, cyc, bc);
    check($sformatf("%s.done", tag), 32'(bus.done), 32'd1);
    check($sformatf("%s.lat", tag), 32'(cyc), sp ? 32'd1 : 32'd34);
    check($sformatf("%s.busy", tag), 32'(bc), sp ? 32'd0 : 32'd33);
    check($sformatf("%s.res", tag), bus.result, exp);
    check($sformatf("%s.rd", tag), 32'(bus.rd_out), 32'(rd));
    tick();
    check($sformatf("%s.pulse", tag), 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] prev_res, x, y;
    logic [4:0]  prev_rd, rd;
    logic [2:0]  f;
    int d0, cyc, bc, r;

    rstn = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.a = '0; bus.b = '0; bus.rd_in = '0;
    repeat (3) tick();
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.res", bus.result, 32'd0);
    check("rst.rd", 32'(bus.rd_out), 32'd0);
    rstn = 1'b1;
    tick();

    do_op("mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    do_op("mulh",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd2, 32'h4000_0000);
    do_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4, 32'hFFFF_FFFF);
    do_op("divu",   OP_DIVU,   32'd100,        32'd7,         5'd5, 32'd14);
    do_op("remu",   OP_REMU,   32'd100,        32'd7,         5'd6, 32'd2);
    do_op("div",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7, 32'hFFFF_FFFD);
    do_op("rem",    OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd8, 32'hFFFF_FFFF);
    do_op("div0",   OP_DIV,    32'd5,          32'd0,         5'd9, 32'hFFFF_FFFF);
    do_op("rem0",   OP_REM,    32'd5,          32'd0,         5'd10, 32'd5);
    do_op("divu0",  OP_DIVU,   32'd9,          32'd0,         5'd11, 32'hFFFF_FFFF);
    do_op("remu0",  OP_REMU,   32'd9,          32'd0,         5'd12, 32'd9);
    do_op("divovf", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    do_op("removf", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0);
    do_op("rd0",    OP_MUL,    32'd6,          32'd9,         5'd0, 32'd54);

    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      rd = 5'($urandom_range(0, 31));
      r  = $urandom_range(0, 7);
      if (r == 0) y = 32'd0;
      if (r == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (r == 2) y = 32'($urandom_range(1, 15));
      do_op("rnd", f, x, y, rd, ref_model(f, x, y));
    end

    // Flush mid-run: no done, outputs held, next start runs normally.
    prev_res = bus.result;
    prev_rd  = bus.rd_out;
    d0 = done_cnt;
    drive(OP_DIVU, 32'd1000, 32'd7, 5'd3);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush.busy", 32'(bus.busy), 32'd0);
    check("flush.done", 32'(bus.done), 32'd0);
    check("flush.res", bus.result, prev_res);
    check("flush.rd", 32'(bus.rd_out), 32'(prev_rd));
    do_op("postflush", OP_DIVU, 32'd1000, 32'd7, 5'd4, 32'd142);
    check("flush.ndone", 32'(done_cnt - d0), 32'd1);

    // Reset mid-run clears everything and never produces done.
    drive(OP_MUL, 32'd123, 32'd456, 5'd21);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    d0 = done_cnt;
    rstn = 1'b0;
    tick();
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.done", 32'(bus.done), 32'd0);
    check("midrst.res", bus.result, 32'd0);
    check("midrst.rd", 32'(bus.rd_out), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (40) tick();
    check("midrst.ndone", 32'(done_cnt - d0), 32'd0);
    do_op("postrst", OP_MUL, 32'd123, 32'd456, 5'd22, 32'd56088);

    // Start pulsed during RUN is ignored.
    d0 = done_cnt;
    drive(OP_DIVU, 32'd1000, 32'd3, 5'd17);
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    drive(OP_MUL, 32'd3, 32'd3, 5'd9);
    tick();
    bus.start = 1'b0;
    wait_done(60, cyc, bc);
    check("runstart.res", bus.result, 32'd333);
    check("runstart.rd", 32'(bus.rd_out), 32'd17);
    repeat (40) tick();
    check("runstart.ndone", 32'(done_cnt - d0), 32'd1);

    // Start in the DONE cycle is dropped; the following IDLE cycle accepts.
    drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    tick();
    bus.start = 1'b0;
    repeat (33) tick();
    check("donecyc.busy", 32'(bus.busy), 32'd0);
    check("donecyc.done", 32'(bus.done), 32'd0);
    drive(OP_MUL, 32'd3, 32'd3, 5'd8);
    tick();
    bus.start = 1'b0;
    check("donecyc.pulse", 32'(bus.done), 32'd1);
    check("donecyc.nobusy", 32'(bus.busy), 32'd0);
    check("donecyc.res", bus.result, 32'hFFFF_FFFE);
    check("donecyc.rd", 32'(bus.rd_out), 32'd7);
    do_op("b2b", OP_MUL, 32'd5, 32'd6, 5'd10, 32'd30);

    // Start together with flush in IDLE does not launch.
    prev_res = bus.result;
    d0 = done_cnt;
    drive(OP_MUL, 32'd11, 32'd11, 5'd12);
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("stflush.busy", 32'(bus.busy), 32'd0);
    repeat (40) tick();
    check("stflush.ndone", 32'(done_cnt - d0), 32'd0);
    check("stflush.res", bus.result, prev_res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It sits between REG_FILE read ports (rd0/rd1 drive a/b) and the register write-back path (result/rd_out drive wd/wa).
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with one shift-add / restoring-subtract step per cycle.
- Pipeline control stalls on busy and writes back on done.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iteration count in RUN; must equal XLEN.

Ports:
clk  input  1  clock; all state updates on posedge.
rstn  input  1  synchronous active-low reset.
start  input  1  request; sampled only in IDLE.
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  input  32  rs1 operand.
b  input  32  rs2 operand.
rd_in  input  5  destination register tag.
flush  input  1  synchronous abort (branch/exception squash).
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse; result/rd_out valid.
result  output  32  registered result; held until the next accepted start.
rd_out  output  5  registered copy of rd_in; held with result.

Behaviour:
- Reset, when rstn=0 at posedge:
  - state=IDLE.
  - busy=0, done=0, result=0, rd_out=0.
  - All internal registers cleared.
  - Reset mid-operation discards the operation; no done is issued.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If start && !flush at edge E0: latch op, rd_in, |a|, |b| and the result sign, then go to RUN with counter=0.
  - Signedness per op: MULH and DIV/REM treat both operands as signed. MULHSU treats a as signed and b as unsigned. The U ops treat both as unsigned.
- Special cases, decided in IDLE at E0:
  - DIV/DIVU with b==0: result quotient=0xFFFFFFFF; REM/REMU with b==0: result=a. Go directly to DONE.
  - DIV with a=0x80000000, b=0xFFFFFFFF: result=0x80000000. REM with the same operands: result=0.
  - In both cases done is high in the cycle after E1.
- RUN:
  - Multiply: one shift-add step per edge into a 64-bit accumulator.
  - Divide: one restoring-division step per edge, producing quotient and remainder.
  - counter increments each edge; after ITER steps, go to FIX.
- FIX:
  - Apply two's-complement negation per the latched sign.
  - MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Load result and rd_out, then go to DONE.
- DONE: done=1 for exactly this cycle, busy=0; return to IDLE.
- Latency:
  - start sampled at E0; the RUN steps occupy edges E1..E32; FIX completes at E33; done is high in the cycle after E34.
  - Back-to-back: a start in the DONE cycle is not accepted. The earliest accepted start is the first IDLE cycle after DONE.
- busy:
  - High in RUN and FIX.
  - Low in IDLE and DONE.
  - Low on the fast special-case path.
- start while busy is ignored; no queueing.
- flush:
  - At any edge, flush=1 forces IDLE. done is not asserted and result/rd_out are unchanged.
  - flush and start together in IDLE: flush wins; start is dropped.
- rd_in=0 is computed normally; REG_FILE drops the write.
- Widths: the product accumulator is 2*XLEN. The remainder register is XLEN+1 to hold the subtract borrow. All arithmetic is unsigned on magnitudes.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams: OP_MUL … OP_REMU.
  - State encodings: S_IDLE, S_RUN, S_FIX, S_DONE.
  - XLEN.
- One sub-module, muldiv_step: the combinational single-iteration datapath.
  - Inputs: mode, accumulator/remainder, multiplicand/divisor.
  - Outputs: next accumulator/remainder and the quotient bit.
  - muldiv_unit owns the FSM, counter, sign handling and the output registers.

Test Plan:
- Multiply and flush-free latency: MUL, a=7, b=0xFFFFFFFD, start at E0 → busy high E1..E33, done pulse after E34, result=0xFFFFFFEB, rd_out=rd_in.
- Signed high product: MULH, a=b=0x80000000 → 0x40000000. MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- Unsigned and signed division: DIVU 100/7 → 14; REMU → 2. DIV -7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Special cases: DIV 5/0 → 0xFFFFFFFF with done after E1 and busy never high. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 after E1.
- Abort and reset: start DIVU, then flush at E10 → busy=0 next cycle, no done, result keeps its old value, and a new start at the next edge completes normally. Separately, rstn=0 mid-RUN → all outputs 0, no done.
- Handshake rules: start pulsed during RUN is ignored, with exactly one done for the first op. start in the DONE cycle is ignored. start together with flush in IDLE does not launch an operation.
